// File: rtl/uart_tx_fifo_drain.sv
// rtl/uart_tx_fifo_drain.sv - 8N1/8N2 UART transmitter draining a first-word-fall-through FIFO
module uart_tx_fifo_drain #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_WIDTH   = 8,
  parameter int STOP_BITS    = 1,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_enable,
  input  logic                  i_fifo_empty,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  output logic                  o_fifo_read_en,
  output logic                  o_tx,
  output logic                  o_busy
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DATA_WIDTH - 1);
  localparam logic             STOP_LAST  = (STOP_BITS == 2);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  stop_idx_q, stop_idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  cnt_zero;
  logic                  load;
  logic                  stop_done;
  logic                  read_en;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    cnt_zero   = (cnt_q == '0);
    load       = i_enable & ~i_fifo_empty;
    stop_done  = (state_q == STOP) & cnt_zero & (stop_idx_q == STOP_LAST);
    // Pop is qualified by reset so the FIFO tail never moves while held in reset.
    read_en    = i_rst_n & load & ((state_q == IDLE) | stop_done);

    case (state_q)
      IDLE: begin
        if (read_en) begin
          shift_d = i_fifo_data;
          cnt_d   = CNT_RELOAD;
          state_d = START;
        end
      end
      START: begin
        if (cnt_zero) begin
          cnt_d   = CNT_RELOAD;
          idx_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_zero) begin
          shift_d = shift_q >> 1;
          cnt_d   = CNT_RELOAD;
          if (idx_q == LAST_IDX) begin
            stop_idx_d = 1'b0;
            state_d    = STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      STOP: begin
        if (stop_done) begin
          // Chaining straight into START gives back-to-back frames with no idle gap.
          if (read_en) begin
            shift_d = i_fifo_data;
            cnt_d   = CNT_RELOAD;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else if (cnt_zero) begin
          stop_idx_d = 1'b1;
          cnt_d      = CNT_RELOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  assign o_fifo_read_en = read_en;
  assign o_tx           = tx_q;
  assign o_busy         = busy_q;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// tb/tb_uart_tx_fifo_drain.sv - scoreboard bench for uart_tx_fifo_drain (1 and 2 stop bits)
module tb_uart_tx_fifo_drain;

  localparam int CPB = 4;
  localparam int DW  = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          empty [2];
  logic [DW-1:0] data  [2];
  logic          re    [2];
  logic          tx    [2];
  logic          busy  [2];

  always #5 clk = ~clk;

  uart_tx_fifo_drain #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(DW), .STOP_BITS(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en),
    .i_fifo_empty(empty[0]), .i_fifo_data(data[0]),
    .o_fifo_read_en(re[0]), .o_tx(tx[0]), .o_busy(busy[0])
  );

  uart_tx_fifo_drain #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(DW), .STOP_BITS(2)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en),
    .i_fifo_empty(empty[1]), .i_fifo_data(data[1]),
    .o_fifo_read_en(re[1]), .o_tx(tx[1]), .o_busy(busy[1])
  );

  int            checks = 0;
  int            errors = 0;
  bit            checking = 1'b0;
  bit            pop_seen [2];
  logic [DW-1:0] fifo_q    [2][$];
  logic [DW-1:0] exp_bytes [2][$];
  bit            exp_tx    [2][$];

  task automatic check(input string name, input int k, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[dut%0d] at %0t: got %b expected %b", name, k + 1, $time, act, exp);
    end
  endtask

  // Reference model: each pop expands the scoreboard byte into its per-cycle line levels.
  initial begin
    pop_seen[0] = 1'b0;
    pop_seen[1] = 1'b0;
    forever begin
      @(negedge clk);
      if (checking) begin
        for (int k = 0; k < 2; k++) begin
          bit            exp_t;
          bit            exp_b;
          bit            exp_r;
          logic [DW-1:0] b;
          exp_b = (exp_tx[k].size() > 0);
          exp_t = exp_b ? exp_tx[k][0] : 1'b1;
          check("tx", k, tx[k], exp_t);
          check("busy", k, busy[k], exp_b);
          if (exp_b) void'(exp_tx[k].pop_front());
          exp_r = rst_n && en && !empty[k] && (exp_tx[k].size() == 0);
          check("read_en", k, re[k], exp_r);
          pop_seen[k] = (re[k] === 1'b1);
          if (exp_r) begin
            if (exp_bytes[k].size() == 0) begin
              checks++;
              errors++;
              $display("FAIL scoreboard[dut%0d] at %0t: got pop expected no byte pending", k + 1, $time);
            end else begin
              b = exp_bytes[k].pop_front();
              repeat (CPB) exp_tx[k].push_back(1'b0);
              for (int i = 0; i < DW; i++) repeat (CPB) exp_tx[k].push_back(b[i]);
              repeat ((k + 1) * CPB) exp_tx[k].push_back(1'b1);
            end
          end
          if (!rst_n) exp_tx[k].delete();
        end
      end
    end
  end

  task automatic refresh(input int k);
    empty[k] = (fifo_q[k].size() == 0);
    data[k]  = empty[k] ? DW'($urandom) : fifo_q[k][0];
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        if (pop_seen[k] && fifo_q[k].size() > 0) void'(fifo_q[k].pop_front());
        refresh(k);
      end
    end
  endtask

  task automatic push_byte(input logic [DW-1:0] b);
    for (int k = 0; k < 2; k++) begin
      fifo_q[k].push_back(b);
      exp_bytes[k].push_back(b);
      refresh(k);
    end
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while ((exp_bytes[0].size() + exp_bytes[1].size() + exp_tx[0].size() + exp_tx[1].size() > 0)
           && n < limit) begin
      tick(1);
      n++;
    end
    if (n >= limit) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout at %0t: got pending work after %0d cycles expected idle", $time, n);
    end
    tick(3);
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    refresh(0);
    refresh(1);
    tick(1);
    checking = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(5);

    push_byte(8'hA5);
    wait_idle(200);

    push_byte(8'h00);
    push_byte(8'hFF);
    wait_idle(300);

    en = 1'b0;
    push_byte(8'h3C);
    push_byte(8'h55);
    tick(20);
    en = 1'b1;
    tick(14);
    en = 1'b0;
    tick(80);
    en = 1'b1;
    wait_idle(300);

    push_byte(8'h5A);
    push_byte(8'h96);
    tick(18);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    wait_idle(300);

    repeat (60) begin
      if ($urandom_range(0, 1) == 1) push_byte(DW'($urandom));
      if ($urandom_range(0, 7) == 0) en = ~en;
      tick($urandom_range(1, 50));
    end
    en = 1'b1;
    wait_idle(5000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
